// File: rtl/cpu_trace_buffer.sv
// Instruction-trace capture buffer: wraps until a PC trigger plus post window, or fills once, then drains oldest-first.
// Optional macro TRACE_TIMESTAMP_EN adds a per-entry cycle timestamp and the rd_ts port.
module cpu_trace_buffer #(
  parameter int XLEN      = 32,
  parameter int DEPTH     = 16,
  parameter int POST_TRIG = 4,
  parameter int TS_W      = 16
) (
  input  logic                       CLK,
  input  logic                       RST_n,
  input  logic                       arm,
  input  logic                       mode,
  input  logic                       trig_en,
  input  logic [XLEN-1:0]            trig_pc,
  input  logic                       cap_valid,
  input  logic [XLEN-1:0]            cap_pc,
  input  logic [31:0]                cap_instr,
  input  logic                       cap_branch,
  input  logic                       cap_zero,
  output logic [1:0]                 state,
  output logic                       triggered,
  output logic [$clog2(DEPTH):0]     entries,
  output logic                       rd_valid,
  input  logic                       rd_ready,
  output logic [XLEN-1:0]            rd_pc,
  output logic [31:0]                rd_instr,
  output logic                       rd_branch,
  output logic                       rd_zero,
`ifdef TRACE_TIMESTAMP_EN
  output logic [TS_W-1:0]            rd_ts,
`endif
  output logic                       rd_last
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL      = CW'(DEPTH);
  localparam logic [AW-1:0] POST_INIT = AW'(POST_TRIG);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || POST_TRIG < 0 || POST_TRIG >= DEPTH || TS_W < 1)
  begin : g_param_check
    $error("cpu_trace_buffer: illegal parameter combination");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_POST  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t          r_state;
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_head;
  logic [AW-1:0]   r_post_cnt;
  logic [CW-1:0]   r_count;
  logic            r_triggered;
  logic            r_mode;
  logic            r_trig_en;
  logic [XLEN-1:0] r_trig_pc;

  logic [XLEN-1:0] r_mem_pc     [DEPTH];
  logic [31:0]     r_mem_instr  [DEPTH];
  logic            r_mem_branch [DEPTH];
  logic            r_mem_zero   [DEPTH];

  logic            w_capture;
  logic            w_hit;
  logic            w_valid;
  logic            w_xfer;
  logic [AW-1:0]   w_wr_ptr_nxt;
  logic [CW-1:0]   w_count_nxt;
  logic [AW-1:0]   w_done_head;

  assign w_capture    = !arm && cap_valid && (r_state == S_ARMED || r_state == S_POST);
  assign w_hit        = (r_state == S_ARMED) && !r_mode && r_trig_en && (cap_pc == r_trig_pc);
  assign w_valid      = (r_state == S_DONE) && (r_count != '0);
  assign w_xfer       = !arm && w_valid && rd_ready;
  assign w_wr_ptr_nxt = r_wr_ptr + 1'b1;
  assign w_count_nxt  = (r_count == FULL) ? FULL : r_count + 1'b1;
  // Once the buffer has wrapped, the oldest entry sits at the next write slot.
  assign w_done_head  = (w_count_nxt == FULL) ? w_wr_ptr_nxt : '0;

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      r_state     <= S_IDLE;
      r_wr_ptr    <= '0;
      r_head      <= '0;
      r_post_cnt  <= '0;
      r_count     <= '0;
      r_triggered <= 1'b0;
      r_mode      <= 1'b0;
      r_trig_en   <= 1'b0;
      r_trig_pc   <= '0;
    end else if (arm) begin
      r_state     <= S_ARMED;
      r_wr_ptr    <= '0;
      r_head      <= '0;
      r_post_cnt  <= '0;
      r_count     <= '0;
      r_triggered <= 1'b0;
      r_mode      <= mode;
      r_trig_en   <= trig_en;
      r_trig_pc   <= trig_pc;
    end else if (w_capture) begin
      r_wr_ptr <= w_wr_ptr_nxt;
      r_count  <= w_count_nxt;
      if (r_state == S_POST) begin
        r_post_cnt <= r_post_cnt - 1'b1;
        if (r_post_cnt == AW'(1)) begin
          r_state <= S_DONE;
          r_head  <= w_done_head;
        end
      end else if (r_mode) begin
        if (w_count_nxt == FULL) begin
          r_state <= S_DONE;
          r_head  <= w_done_head;
        end
      end else if (w_hit) begin
        r_triggered <= 1'b1;
        if (POST_TRIG == 0) begin
          r_state <= S_DONE;
          r_head  <= w_done_head;
        end else begin
          r_state    <= S_POST;
          r_post_cnt <= POST_INIT;
        end
      end
    end else if (w_xfer) begin
      r_head  <= r_head + 1'b1;
      r_count <= r_count - 1'b1;
      if (r_count == CW'(1)) begin
        r_state <= S_IDLE;
      end
    end
  end

  // Trace storage is deliberately left uncleared by reset.
  always_ff @(posedge CLK) begin
    if (w_capture) begin
      r_mem_pc[r_wr_ptr]     <= cap_pc;
      r_mem_instr[r_wr_ptr]  <= cap_instr;
      r_mem_branch[r_wr_ptr] <= cap_branch;
      r_mem_zero[r_wr_ptr]   <= cap_zero;
    end
  end

`ifdef TRACE_TIMESTAMP_EN
  logic [TS_W-1:0] r_ts;
  logic [TS_W-1:0] r_mem_ts [DEPTH];

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      r_ts <= '0;
    end else if (arm) begin
      r_ts <= '0;
    end else begin
      r_ts <= r_ts + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (w_capture) begin
      r_mem_ts[r_wr_ptr] <= r_ts;
    end
  end

  assign rd_ts = w_valid ? r_mem_ts[r_head] : '0;
`endif

  assign state     = r_state;
  assign triggered = r_triggered;
  assign entries   = r_count;
  assign rd_valid  = w_valid;
  assign rd_last   = w_valid && (r_count == CW'(1));
  assign rd_pc     = w_valid ? r_mem_pc[r_head]     : '0;
  assign rd_instr  = w_valid ? r_mem_instr[r_head]  : '0;
  assign rd_branch = w_valid ? r_mem_branch[r_head] : 1'b0;
  assign rd_zero   = w_valid ? r_mem_zero[r_head]   : 1'b0;

endmodule

// File: tb/tb_cpu_trace_buffer.sv
// Directed bench for cpu_trace_buffer: a POST_TRIG=4 instance plus a POST_TRIG=0 instance sharing all inputs.
module tb_cpu_trace_buffer;

  logic        CLK = 1'b0;
  logic        RST_n = 1'b0;
  logic        arm = 1'b0, mode = 1'b0, trig_en = 1'b0;
  logic [31:0] trig_pc = '0;
  logic        cap_valid = 1'b0;
  logic [31:0] cap_pc = '0, cap_instr = '0;
  logic        cap_branch = 1'b0, cap_zero = 1'b0;
  logic        rd_ready = 1'b0;

  logic [1:0]  state, state2;
  logic        triggered, triggered2;
  logic [4:0]  entries, entries2;
  logic        rd_valid, rd_valid2, rd_last, rd_last2;
  logic [31:0] rd_pc, rd_pc2, rd_instr, rd_instr2;
  logic        rd_branch, rd_branch2, rd_zero, rd_zero2;

  int errors = 0;
  int checks = 0;

  cpu_trace_buffer #(.XLEN(32), .DEPTH(16), .POST_TRIG(4), .TS_W(16)) dut (
    .CLK(CLK), .RST_n(RST_n), .arm(arm), .mode(mode), .trig_en(trig_en), .trig_pc(trig_pc),
    .cap_valid(cap_valid), .cap_pc(cap_pc), .cap_instr(cap_instr), .cap_branch(cap_branch),
    .cap_zero(cap_zero), .state(state), .triggered(triggered), .entries(entries),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_pc(rd_pc), .rd_instr(rd_instr),
    .rd_branch(rd_branch), .rd_zero(rd_zero), .rd_last(rd_last)
  );

  cpu_trace_buffer #(.XLEN(32), .DEPTH(16), .POST_TRIG(0), .TS_W(16)) dut2 (
    .CLK(CLK), .RST_n(RST_n), .arm(arm), .mode(mode), .trig_en(trig_en), .trig_pc(trig_pc),
    .cap_valid(cap_valid), .cap_pc(cap_pc), .cap_instr(cap_instr), .cap_branch(cap_branch),
    .cap_zero(cap_zero), .state(state2), .triggered(triggered2), .entries(entries2),
    .rd_valid(rd_valid2), .rd_ready(rd_ready), .rd_pc(rd_pc2), .rd_instr(rd_instr2),
    .rd_branch(rd_branch2), .rd_zero(rd_zero2), .rd_last(rd_last2)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] instrOf(input logic [31:0] pc);
    return {16'hC0DE, pc[15:0]};
  endfunction

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  // The arm cycle also presents a capture, which must not be recorded.
  task automatic doArm(input logic m, input logic te, input logic [31:0] tpc);
    arm = 1'b1; mode = m; trig_en = te; trig_pc = tpc;
    cap_valid = 1'b1; cap_pc = 32'hDEAD_0000; cap_instr = 32'hFFFF_FFFF;
    tick;
    arm = 1'b0; cap_valid = 1'b0;
  endtask

  task automatic doCapture(input logic [31:0] pc);
    cap_valid = 1'b1; cap_pc = pc; cap_instr = instrOf(pc);
    cap_branch = pc[2]; cap_zero = pc[3];
    tick;
    cap_valid = 1'b0;
  endtask

  task automatic test_reset;
    #2;
    checks++; if (state !== 2'd0) begin errors++; $display("[TB] FAIL reset_state got %0d want 0", state); end
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_rd_valid got %b want 0", rd_valid); end
    checks++; if (entries !== 5'd0) begin errors++; $display("[TB] FAIL reset_entries got %0d want 0", entries); end
    checks++; if (triggered !== 1'b0) begin errors++; $display("[TB] FAIL reset_triggered got %b want 0", triggered); end
    checks++; if (rd_pc !== 32'h0 || rd_last !== 1'b0) begin errors++; $display("[TB] FAIL reset_rd_data got pc=%h last=%b want 0/0", rd_pc, rd_last); end
    @(posedge CLK); #1;
    RST_n = 1'b1;
    tick;
  endtask

  task automatic test_oneshot;
    doArm(1'b1, 1'b0, 32'h0);
    checks++; if (state !== 2'd1) begin errors++; $display("[TB] FAIL oneshot_armed got %0d want 1", state); end
    checks++; if (entries !== 5'd0) begin errors++; $display("[TB] FAIL oneshot_arm_entries got %0d want 0", entries); end
    for (int i = 0; i < 20; i++) begin
      doCapture(32'(i * 4));
      if (i == 14) begin
        checks++; if (state !== 2'd1) begin errors++; $display("[TB] FAIL oneshot_before_full got %0d want 1", state); end
      end
      if (i == 15 || i == 19) begin
        checks++; if (state !== 2'd3) begin errors++; $display("[TB] FAIL oneshot_done_%0d got %0d want 3", i, state); end
        checks++; if (entries !== 5'd16) begin errors++; $display("[TB] FAIL oneshot_entries_%0d got %0d want 16", i, entries); end
      end
    end
    rd_ready = 1'b1;
    for (int b = 0; b < 16; b++) begin
      checks++; if (rd_valid !== 1'b1 || rd_pc !== 32'(b * 4)) begin errors++; $display("[TB] FAIL oneshot_beat%0d got v=%b pc=%h want 1/%h", b, rd_valid, rd_pc, b * 4); end
      checks++; if (rd_instr !== instrOf(32'(b * 4))) begin errors++; $display("[TB] FAIL oneshot_instr%0d got %h want %h", b, rd_instr, instrOf(32'(b * 4))); end
      checks++; if (rd_last !== (b == 15)) begin errors++; $display("[TB] FAIL oneshot_last%0d got %b want %b", b, rd_last, b == 15); end
      tick;
    end
    rd_ready = 1'b0;
    checks++; if (state !== 2'd0 || rd_valid !== 1'b0 || entries !== 5'd0) begin errors++; $display("[TB] FAIL oneshot_end got s=%0d v=%b e=%0d want 0/0/0", state, rd_valid, entries); end
  endtask

  task automatic test_trigger;
    doArm(1'b0, 1'b1, 32'h40);
    for (int i = 0; i <= 20; i++) begin
      doCapture(32'(i * 4));
      if (i == 15) begin
        checks++; if (triggered !== 1'b0 || state !== 2'd1) begin errors++; $display("[TB] FAIL trig_pre got t=%b s=%0d want 0/1", triggered, state); end
      end
      if (i == 16) begin
        checks++; if (triggered !== 1'b1 || state !== 2'd2) begin errors++; $display("[TB] FAIL trig_fire got t=%b s=%0d want 1/2", triggered, state); end
      end
      if (i == 19) begin
        checks++; if (state !== 2'd2) begin errors++; $display("[TB] FAIL trig_post got %0d want 2", state); end
      end
    end
    checks++; if (state !== 2'd3 || entries !== 5'd16) begin errors++; $display("[TB] FAIL trig_done got s=%0d e=%0d want 3/16", state, entries); end
    rd_ready = 1'b1;
    for (int b = 0; b < 16; b++) begin
      checks++; if (rd_pc !== 32'(32'h14 + b * 4) || rd_last !== (b == 15)) begin errors++; $display("[TB] FAIL trig_beat%0d got pc=%h last=%b want %h/%b", b, rd_pc, rd_last, 32'h14 + b * 4, b == 15); end
      checks++; if (rd_branch !== rd_pc[2] || rd_zero !== rd_pc[3] || rd_instr !== instrOf(32'(32'h14 + b * 4))) begin errors++; $display("[TB] FAIL trig_flags%0d got br=%b z=%b instr=%h", b, rd_branch, rd_zero, rd_instr); end
      tick;
    end
    rd_ready = 1'b0;
    checks++; if (state !== 2'd0 || triggered !== 1'b1) begin errors++; $display("[TB] FAIL trig_end got s=%0d t=%b want 0/1", state, triggered); end
  endtask

  task automatic test_trig_first;
    doArm(1'b0, 1'b1, 32'h100);
    doCapture(32'h100);
    checks++; if (state2 !== 2'd3 || entries2 !== 5'd1) begin errors++; $display("[TB] FAIL first_done got s=%0d e=%0d want 3/1", state2, entries2); end
    checks++; if (rd_valid2 !== 1'b1 || rd_last2 !== 1'b1 || rd_pc2 !== 32'h100) begin errors++; $display("[TB] FAIL first_beat got v=%b l=%b pc=%h want 1/1/100", rd_valid2, rd_last2, rd_pc2); end
    checks++; if (triggered2 !== 1'b1 || state !== 2'd2) begin errors++; $display("[TB] FAIL first_trig got t2=%b s=%0d want 1/2", triggered2, state); end
    rd_ready = 1'b1;
    tick;
    rd_ready = 1'b0;
    checks++; if (state2 !== 2'd0 || rd_valid2 !== 1'b0 || triggered2 !== 1'b1) begin errors++; $display("[TB] FAIL first_end got s=%0d v=%b t=%b want 0/0/1", state2, rd_valid2, triggered2); end
  endtask

  task automatic test_backpressure;
    int b;
    doArm(1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 16; i++) doCapture(32'(32'h200 + i * 4));
    b = 0;
    for (int c = 0; c < 40 && b < 16; c++) begin
      rd_ready = (c % 2 == 0);
      checks++; if (rd_valid !== 1'b1 || rd_pc !== 32'(32'h200 + b * 4) || rd_instr !== instrOf(32'(32'h200 + b * 4))) begin errors++; $display("[TB] FAIL bp_cycle%0d got v=%b pc=%h want 1/%h", c, rd_valid, rd_pc, 32'h200 + b * 4); end
      checks++; if (entries !== 5'(16 - b)) begin errors++; $display("[TB] FAIL bp_entries%0d got %0d want %0d", c, entries, 16 - b); end
      tick;
      if (rd_ready) b++;
    end
    rd_ready = 1'b0;
    checks++; if (state !== 2'd0 || rd_valid !== 1'b0) begin errors++; $display("[TB] FAIL bp_end got s=%0d v=%b want 0/0", state, rd_valid); end
  endtask

  task automatic test_rearm;
    doArm(1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 16; i++) doCapture(32'(32'h300 + i * 4));
    rd_ready = 1'b1;
    repeat (3) tick;
    rd_ready = 1'b0;
    checks++; if (rd_pc !== 32'h30C || entries !== 5'd13) begin errors++; $display("[TB] FAIL rearm_partial got pc=%h e=%0d want 30c/13", rd_pc, entries); end
    doArm(1'b0, 1'b1, 32'h400);
    checks++; if (rd_valid !== 1'b0 || state !== 2'd1 || entries !== 5'd0) begin errors++; $display("[TB] FAIL rearm_abort got v=%b s=%0d e=%0d want 0/1/0", rd_valid, state, entries); end
    doCapture(32'h400);
    checks++; if (state2 !== 2'd3 || entries2 !== 5'd1 || rd_pc2 !== 32'h400) begin errors++; $display("[TB] FAIL rearm_index0 got s=%0d e=%0d pc=%h want 3/1/400", state2, entries2, rd_pc2); end
    checks++; if (state !== 2'd2 || entries !== 5'd1 || triggered !== 1'b1) begin errors++; $display("[TB] FAIL rearm_post got s=%0d e=%0d t=%b want 2/1/1", state, entries, triggered); end
  endtask

  task automatic test_async_reset;
    doCapture(32'h404);
    checks++; if (state !== 2'd2) begin errors++; $display("[TB] FAIL areset_pre got %0d want 2", state); end
    #3;
    RST_n = 1'b0;
    #1;
    checks++; if (state !== 2'd0 || rd_valid !== 1'b0) begin errors++; $display("[TB] FAIL areset_state got s=%0d v=%b want 0/0", state, rd_valid); end
    checks++; if (entries !== 5'd0 || triggered !== 1'b0) begin errors++; $display("[TB] FAIL areset_cnt got e=%0d t=%b want 0/0", entries, triggered); end
    checks++; if (state2 !== 2'd0 || rd_valid2 !== 1'b0) begin errors++; $display("[TB] FAIL areset_dut2 got s=%0d v=%b want 0/0", state2, rd_valid2); end
    #2;
    RST_n = 1'b1;
    tick;
  endtask

  initial begin
    test_reset;
    test_oneshot;
    test_trigger;
    test_trig_first;
    test_backpressure;
    test_rearm;
    test_async_reset;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cpu_trace_buffer.md
Name: cpu_trace_buffer

Overview:
Parametrised instruction-trace capture block for the single-cycle CPU.
- Snoops per-instruction signals from the CPU top (pc, instruction word, branch, zero) into a circular buffer.
- Buffer is either filled once, or wraps continuously until a PC-match trigger fires plus a post-trigger window.
- Captured history drains oldest-first over a valid/ready readout port to a bench or debug host.

Parameters:
XLEN, 32, width of pc and trigger compare
DEPTH, 16, buffer entries; power of 2, >= 2
POST_TRIG, 4, entries captured after the trigger entry; 0..DEPTH-1
TS_W, 16, timestamp width (only with TRACE_TIMESTAMP_EN)

Ports:
CLK  in  1  clock, rising edge
RST_n  in  1  asynchronous active-low reset
arm  in  1  single-cycle pulse: clear buffer and start capture
mode  in  1  0 = wrap until trigger, 1 = one-shot fill; latched at arm
trig_en  in  1  enable PC trigger (mode 0); latched at arm
trig_pc  in  XLEN  trigger PC; latched at arm
cap_valid  in  1  instruction retires this cycle (tie 1 for single-cycle core)
cap_pc  in  XLEN  retiring pc
cap_instr  in  32  retiring instruction word
cap_branch  in  1  branch signal
cap_zero  in  1  ALU zero flag
state  out  2  0 IDLE, 1 ARMED, 2 POST, 3 DONE
triggered  out  1  trigger has fired since last arm
entries  out  $clog2(DEPTH)+1  stored count; in DONE, entries not yet read
rd_valid  out  1  readout entry available
rd_ready  in  1  consumer accepts entry
rd_pc  out  XLEN  head entry pc
rd_instr  out  32  head entry instruction
rd_branch  out  1  head entry branch
rd_zero  out  1  head entry zero
rd_last  out  1  head entry is the final one

Behaviour:
- Reset (RST_n low, async): state=IDLE, wr_ptr=0, count=0, post_cnt=0, triggered=0, rd_valid=0, rd_last=0, entries=0. All rd_* data outputs are 0. Buffer RAM is not cleared; contents are don't-care. Deassertion is honoured at the next CLK edge.
- arm (any state, highest priority):
  - Next state is ARMED; wr_ptr=0, count=0, triggered=0; any readout is aborted (rd_valid=0 next cycle).
  - mode, trig_en and trig_pc are latched.
  - The capture presented in the arm cycle is NOT recorded.
- Capture: only in ARMED/POST with cap_valid=1.
  - Write {pc, instr, branch, zero} at wr_ptr; wr_ptr = (wr_ptr+1) mod DEPTH.
  - count = min(count+1, DEPTH). When full, the oldest entry is overwritten.
  - cap_valid=0: no write, no state change.
- ARMED, mode 1:
  - Trigger is ignored.
  - The write that makes count==DEPTH moves the state to DONE.
- ARMED, mode 0, trig_en=1 and cap_pc==trig_pc on a captured cycle:
  - That entry is recorded and triggered=1.
  - If POST_TRIG==0, go to DONE; otherwise go to POST with post_cnt=POST_TRIG.
  - With trig_en=0, capture wraps indefinitely until the next arm.
- POST: each capture decrements post_cnt; the capture that brings it to 0 moves the state to DONE. Trigger compare is inactive in POST.
- DONE (readout):
  - head = (count==DEPTH) ? wr_ptr : 0; remaining = count.
  - rd_valid=1 while remaining>0. rd_* show the head entry and stay stable while rd_valid && !rd_ready.
  - Transfer on rd_valid && rd_ready: head advances mod DEPTH, remaining decrements.
  - rd_last=1 when remaining==1.
  - After the last transfer: rd_valid=0, state=IDLE, entries=0. triggered holds until the next arm.
  - No captures occur in DONE or IDLE.
- Single-cycle read: the buffer is register-based; rd_* are combinational from head.

Optional Feature:
TRACE_TIMESTAMP_EN
- Defined:
  - A free-running TS_W-bit cycle counter is added. It resets to 0 on RST_n and on arm, and wraps at 2^TS_W.
  - Each entry additionally stores the counter value at capture.
  - Extra port: rd_ts  out  TS_W, the head entry timestamp, reset 0.
- Undefined: no counter, no rd_ts port, no timestamp storage.

Test Plan:
1. Reset: drive RST_n low mid-cycle during POST -> state=0, rd_valid=0, entries=0, triggered=0 immediately, without waiting for a clock edge.
2. mode=1, DEPTH=16: arm, then 20 captures with pc 0x0,0x4,... -> DONE after the 16th capture (pc 0x3C). Readout gives 16 beats, pc 0x0..0x3C, rd_last only on the 16th beat, then IDLE.
3. mode=0, trig_pc=0x40, POST_TRIG=4: pc 0x0,0x4,... -> triggered=1 at 0x40, DONE after 0x50. Readout is 16 beats, pc 0x14..0x50, oldest first.
4. mode=0, trig_pc equals the first captured pc, POST_TRIG=0 -> DONE next cycle with entries=1; one beat with rd_last=1.
5. Backpressure: toggle rd_ready 1,0,1,0 during readout -> rd_pc/rd_instr stable while stalled. Each entry is delivered exactly once and entries decrements only on a transfer.
6. Pulse arm after 3 of 16 beats have been read -> rd_valid=0 next cycle, state=ARMED, entries=0; the next capture lands at index 0.
